// File: rtl/alu_exec_stage.sv
// ALU execute stage: computes one ALU operation per accepted input, holds the
// result in a two-entry elastic buffer (main + skid) and exposes it through a
// valid/ready handshake.  Also keeps retired-operation and illegal-op counters.

package alu_exec_pkg;
  localparam logic [4:0] OPADD  = 5'h00;
  localparam logic [4:0] OPSUB  = 5'h01;
  localparam logic [4:0] OPAND  = 5'h02;
  localparam logic [4:0] OPOR   = 5'h03;
  localparam logic [4:0] OPSLT  = 5'h04;
  localparam logic [4:0] OPNULL = 5'h1F;
endpackage

module alu_exec_stage
  import alu_exec_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_alu_ctrl,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [4:0]        in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic [4:0]        out_rd,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [7:0]        illegal_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              illegal;
    logic [4:0]        rd;
  } entry_t;

  state_t state;
  entry_t main_q;
  entry_t skid_q;
  entry_t new_entry;
  logic   in_xfer;
  logic   out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // ALU: evaluate the incoming operation so it can be captured at acceptance.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no code path leaves it unassigned and no latch is inferred.
    new_entry    = '0;
    new_entry.rd = in_rd;
    unique case (in_alu_ctrl)
      OPADD:   new_entry.result = in_a + in_b;
      OPSUB:   new_entry.result = in_a - in_b;
      OPAND:   new_entry.result = in_a & in_b;
      OPOR:    new_entry.result = in_a | in_b;
      OPSLT:   new_entry.result = {{(DATA_W-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      default: new_entry.illegal = 1'b1;
    endcase
    new_entry.zero = (new_entry.result == '0);
  end

  // Buffer state machine: EMPTY/ONE/TWO occupancy with registered handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the payload registers are reset too, because the outputs must
      // read zero while reset is held, not just be marked invalid.
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_q    <= new_entry;
            state     <= ONE;
            out_valid <= 1'b1;
          end
          in_ready <= 1'b1;
        end
        ONE: begin
          if (in_xfer && !out_xfer) begin
            skid_q   <= new_entry;
            state    <= TWO;
            in_ready <= 1'b0;
          end else if (!in_xfer && out_xfer) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end else begin
            if (in_xfer) main_q <= new_entry;
            in_ready <= 1'b1;
          end
        end
        TWO: begin
          if (out_xfer) begin
            main_q   <= skid_q;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // Counters: retired wraps, illegal saturates; a flush cycle counts nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
      illegal_cnt <= '0;
    end else if (!flush) begin
      if (out_xfer) retired_cnt <= retired_cnt + CNT_W'(1);
      if (in_xfer && new_entry.illegal && illegal_cnt != 8'hFF)
        illegal_cnt <= illegal_cnt + 8'd1;
    end
  end

  assign out_result  = main_q.result;
  assign out_zero    = main_q.zero;
  assign out_rd      = main_q.rd;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.

module tb_alu_exec_stage;
  import alu_exec_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_alu_ctrl;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic [4:0]  out_rd;
  logic        out_illegal;
  logic [15:0] retired_cnt;
  logic [7:0]  illegal_cnt;

  alu_exec_stage #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_alu_ctrl(in_alu_ctrl),
    .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_rd(out_rd),
    .out_illegal(out_illegal), .retired_cnt(retired_cnt), .illegal_cnt(illegal_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of expected results plus counters.
  typedef struct {
    logic [31:0] res;
    logic        ill;
    logic [4:0]  rd;
  } exp_t;

  exp_t        m_q[$];
  logic        m_rdy;
  logic [15:0] m_ret;
  int          m_ill;

  function automatic exp_t ref_alu(input logic [4:0] c, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] rd);
    exp_t e;
    e.rd  = rd;
    e.ill = 1'b0;
    e.res = 32'h0;
    case (c)
      OPADD: e.res = 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      OPSUB: e.res = 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
      OPAND: e.res = a & b;
      OPOR:  e.res = a | b;
      OPSLT: begin
        // Differing signs: the negative operand is smaller; otherwise unsigned order holds.
        if (a[31] != b[31]) e.res = {31'h0, a[31]};
        else                e.res = {31'h0, a < b};
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_rdy = 1'b0;
    m_ret = '0;
    m_ill = 0;
  endtask

  task automatic compare_all();
    check("out_valid", out_valid, m_q.size() != 0);
    check("in_ready", in_ready, m_rdy);
    check("retired_cnt", retired_cnt, m_ret);
    check("illegal_cnt", illegal_cnt, m_ill);
    if (m_q.size() != 0) begin
      check("out_result", out_result, m_q[0].res);
      check("out_zero", out_zero, m_q[0].res == 32'h0);
      check("out_illegal", out_illegal, m_q[0].ill);
      check("out_rd", out_rd, m_q[0].rd);
    end
  endtask

  // One clock: drive inputs, advance the model by the same rules, compare.
  task automatic cycle(input logic v, input logic [4:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic ordy, input logic fl);
    logic in_x;
    logic out_x;
    exp_t e;
    in_valid = v; in_alu_ctrl = c; in_a = a; in_b = b; in_rd = rd;
    out_ready = ordy; flush = fl;
    in_x  = v && m_rdy;
    out_x = (m_q.size() != 0) && ordy;
    @(posedge clk);
    #1;
    if (fl) begin
      m_q.delete();
    end else begin
      if (out_x) begin
        void'(m_q.pop_front());
        m_ret = m_ret + 16'd1;
      end
      if (in_x) begin
        e = ref_alu(c, a, b, rd);
        m_q.push_back(e);
        if (e.ill && m_ill < 255) m_ill++;
      end
    end
    m_rdy = fl ? 1'b1 : (m_q.size() < 2);
    compare_all();
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, OPADD, 32'h0, 32'h0, 5'd0, ordy, 1'b0);
  endtask

  typedef struct {
    logic [4:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        ill;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [15:0] ret_snap;
    logic [7:0]  ill_snap;
    logic [4:0]  rc;
    logic [31:0] ra;
    logic [31:0] rb;

    tbl[0]  = '{OPADD, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0};
    tbl[1]  = '{OPADD, 32'h5,        32'h7,        32'hC,        1'b0, 1'b0};
    tbl[2]  = '{OPSUB, 32'h3,        32'h5,        32'hFFFFFFFE, 1'b0, 1'b0};
    tbl[3]  = '{OPSUB, 32'h9,        32'h9,        32'h0,        1'b1, 1'b0};
    tbl[4]  = '{OPAND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
    tbl[5]  = '{OPOR,  32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0};
    tbl[6]  = '{OPSLT, 32'h80000000, 32'h1,        32'h1,        1'b0, 1'b0};
    tbl[7]  = '{OPSLT, 32'h5,        32'hFFFFFFFF, 32'h0,        1'b1, 1'b0};
    tbl[8]  = '{OPSLT, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h1,        1'b0, 1'b0};
    tbl[9]  = '{OPSLT, 32'h7FFFFFFF, 32'h80000000, 32'h0,        1'b1, 1'b0};
    tbl[10] = '{OPNULL, 32'h7,       32'h9,        32'h0,        1'b1, 1'b1};
    tbl[11] = '{5'h0A, 32'h1,        32'h2,        32'h0,        1'b1, 1'b1};

    // Reset state, checked while reset is held.
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_alu_ctrl = OPADD; in_a = '0; in_b = '0; in_rd = '0;
    model_reset();
    #12;
    compare_all();
    check("rst_out_result", out_result, 32'h0);
    check("rst_out_zero", out_zero, 1'b0);
    check("rst_out_rd", out_rd, 5'd0);
    check("rst_out_illegal", out_illegal, 1'b0);
    rst_n = 1'b1;
    idle(1'b1);
    check("ready_after_reset", in_ready, 1'b1);

    // Directed vectors streamed back to back with out_ready=1.
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, tbl[i].ctrl, tbl[i].a, tbl[i].b, 5'(i), 1'b1, 1'b0);
      check($sformatf("vec%0d_result", i), out_result, tbl[i].res);
      check($sformatf("vec%0d_zero", i), out_zero, tbl[i].zero);
      check($sformatf("vec%0d_illegal", i), out_illegal, tbl[i].ill);
      check($sformatf("vec%0d_retired", i), retired_cnt, 16'(i));
    end
    idle(1'b1);
    check("vec_drain_retired", retired_cnt, 16'd12);

    // Backpressure: two ops fill main + skid, output holds the older one.
    cycle(1'b1, OPADD, 32'h1, 32'h2, 5'd3, 1'b0, 1'b0);
    cycle(1'b1, OPOR,  32'h4, 32'h8, 5'd7, 1'b0, 1'b0);
    check("full_in_ready", in_ready, 1'b0);
    check("full_rd", out_rd, 5'd3);
    cycle(1'b1, OPSUB, 32'h9, 32'h1, 5'd9, 1'b0, 1'b0);
    check("hold_rd", out_rd, 5'd3);
    check("hold_result", out_result, 32'h3);
    idle(1'b1);
    check("second_rd", out_rd, 5'd7);
    check("second_result", out_result, 32'hC);
    check("after_promote_ready", in_ready, 1'b1);
    idle(1'b1);
    check("drained_valid", out_valid, 1'b0);

    // Illegal counter saturation.
    for (int i = 0; i < 300; i++)
      cycle(1'b1, OPNULL, 32'h7, 32'h9, 5'd1, 1'b1, 1'b0);
    check("illegal_sat", illegal_cnt, 8'd255);
    idle(1'b1);

    // Flush from TWO with a simultaneous input.
    cycle(1'b1, OPADD, 32'h1, 32'h1, 5'd2, 1'b0, 1'b0);
    cycle(1'b1, OPADD, 32'h2, 32'h2, 5'd4, 1'b0, 1'b0);
    ret_snap = retired_cnt;
    ill_snap = illegal_cnt;
    cycle(1'b1, OPNULL, 32'h0, 32'h0, 5'd6, 1'b1, 1'b1);
    check("flush_valid", out_valid, 1'b0);
    check("flush_ready", in_ready, 1'b1);
    check("flush_retired", retired_cnt, ret_snap);
    check("flush_illegal", illegal_cnt, ill_snap);
    idle(1'b1);

    // Asynchronous reset in the middle of a cycle while holding one entry.
    cycle(1'b1, OPADD, 32'h10, 32'h20, 5'd5, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_ready", in_ready, 1'b0);
    check("async_rst_retired", retired_cnt, 16'd0);
    check("async_rst_illegal", illegal_cnt, 8'd0);
    check("async_rst_result", out_result, 32'h0);
    model_reset();
    #1;
    rst_n = 1'b1;
    idle(1'b1);
    check("ready_after_midrst", in_ready, 1'b1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 7))
        0: rc = OPADD;
        1: rc = OPSUB;
        2: rc = OPAND;
        3: rc = OPOR;
        4: rc = OPSLT;
        5: rc = OPNULL;
        default: rc = 5'($urandom_range(5, 30));
      endcase
      ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      cycle($urandom_range(0, 3) != 0, rc, ra, rb, 5'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
